// File: rtl/pll_phase_ctrl.sv
// Reset/lock sequencer and dynamic phase-shift driver for an ECP5 EHXPLLL.
// Runs on the free-running reference clock; every output comes straight from a flop.
module pll_phase_ctrl #(
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 4,
    parameter int GAP_CYC      = 4,
    parameter int STEP_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              done,
    output logic              busy,
    output logic              locked_o,
    output logic              lock_err,
    output logic [7:0]        fail_cnt,
    input  logic              pll_locked,
    output logic              pll_rst,
    output logic [1:0]        pll_phasesel,
    output logic              pll_phasedir,
    output logic              pll_phasestep,
    output logic              pll_phaseloadreg
);

    typedef enum logic [2:0] {
        ST_RST, ST_WAIT_LOCK, ST_IDLE, ST_SETUP, ST_PULSE, ST_GAP, ST_DONE
    } state_t;

    localparam logic [31:0] RST_LAST   = 32'(RST_CYC - 1);
    localparam logic [31:0] TO_LAST    = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] SETUP_LAST = 32'(SETUP_CYC - 1);
    localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYC - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);

    state_t              state_q;
    logic [31:0]         cnt_q;
    logic [STEP_W-1:0]   steps_q;
    logic                sync_q, locked_q;
    logic                ready_q, done_q, busy_q, lock_err_q, rst_q;
    logic [7:0]          fail_q;
    logic [7:0]          fail_d;
    logic [1:0]          sel_q;
    logic                dir_q, step_q;

    assign fail_d = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;

    // Two-flop synchronizer for the asynchronous LOCK pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync_q   <= pll_locked;
            locked_q <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            steps_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            lock_err_q <= 1'b0;
            rst_q      <= 1'b1;
            fail_q     <= '0;
            sel_q      <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b1;
        end else begin
            lock_err_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                        rst_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q    <= ST_RST;
                        cnt_q      <= '0;
                        rst_q      <= 1'b1;
                        lock_err_q <= 1'b1;
                        fail_q     <= fail_d;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_IDLE: begin
                    // A lost lock wins over a request arriving in the same cycle.
                    if (!locked_q) begin
                        state_q <= ST_RST;
                        cnt_q   <= '0;
                        rst_q   <= 1'b1;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        fail_q  <= fail_d;
                    end else if (req_valid) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        sel_q   <= req_sel;
                        dir_q   <= req_dir;
                        steps_q <= req_steps;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q <= '0;
                        if (steps_q == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PULSE;
                            step_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_q <= ST_GAP;
                        cnt_q   <= '0;
                        step_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        steps_q <= steps_q - 1'b1;
                        if (steps_q == STEP_W'(1)) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_PULSE;
                            step_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_RST;
                    cnt_q   <= '0;
                    rst_q   <= 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    step_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = ready_q;
    assign done             = done_q;
    assign busy             = busy_q;
    assign locked_o         = locked_q;
    assign lock_err         = lock_err_q;
    assign fail_cnt         = fail_q;
    assign pll_rst          = rst_q;
    assign pll_phasesel     = sel_q;
    assign pll_phasedir     = dir_q;
    assign pll_phasestep    = step_q;
    assign pll_phaseloadreg = 1'b1;

endmodule
